// File: rtl/conv_func_acc.sv
// ---------------------------------------------------------------------------
// conv_func_acc
//
// Convolution functional unit for the CIM layer pipeline. For every kernel
// position (channel) it streams the crossbar row writes, pulses a compute
// start, waits for the crossbar to finish, then reduces the per-tile column
// results across vertical tiles (one horizontal tile per cycle, saturating
// to the output width). The finished vector is offered to the next layer
// over a valid/ready handshake. One i_start runs num_channels channels.
//
// Optional build macro:
//   CONV_FUNC_RELU_EN  - when defined, negative saturated results are stored
//                        as 0 (fused ReLU). Latency is the same either way.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   i_start      begin a channel sequence (only looked at while idle)
//   o_busy       high whenever the unit is not idle
//   i_cim_busy   crossbar cannot take a write or start this cycle
//   o_cim_we     crossbar row write enable
//   o_cim_addr   crossbar row address
//   o_cim_start  one-cycle crossbar compute start
//   i_cim_done   one-cycle pulse, i_data valid and held until next start
//   i_data       signed column results [h tile][v tile][column]
//   o_channel    index of the channel in flight
//   o_valid      o_data holds a complete channel result
//   i_ready      next layer accepts o_data
//   o_data       signed result vector
// ---------------------------------------------------------------------------
module conv_func_acc #(
  parameter int input_size           = 201,
  parameter int output_size          = 512,
  parameter int xbar_size            = 256,
  parameter int h_cim_tiles          = (output_size + xbar_size - 1) / xbar_size,
  parameter int v_cim_tiles          = (input_size + xbar_size - 1) / xbar_size,
  parameter int num_channels         = 4,
  parameter int datatype_size        = 8,
  parameter int output_datatype_size = 16,
  localparam int ADDR_W = $clog2(xbar_size),
  localparam int CH_W   = (num_channels > 1) ? $clog2(num_channels) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_busy,
  input  logic                  i_cim_busy,
  output logic                  o_cim_we,
  output logic [ADDR_W-1:0]     o_cim_addr,
  output logic                  o_cim_start,
  input  logic                  i_cim_done,
  input  logic [h_cim_tiles-1:0][v_cim_tiles-1:0][xbar_size-1:0][datatype_size-1:0] i_data,
  output logic [CH_W-1:0]       o_channel,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [output_size-1:0][output_datatype_size-1:0] o_data
);

  localparam int ROWS  = (input_size < xbar_size) ? input_size : xbar_size;
  localparam int H_W   = (h_cim_tiles > 1) ? $clog2(h_cim_tiles) : 1;
  localparam int ACC_W = datatype_size + $clog2(v_cim_tiles) + 1;
  // One bit wider than both the accumulator and the output so the clamp
  // limits and the sum can be compared without any wrap-around.
  localparam int CMP_W = ((ACC_W > output_datatype_size) ? ACC_W : output_datatype_size) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_START,
    S_WAIT,
    S_ACCUM,
    S_OUT
  } state_t;

  state_t                                           state_q;
  logic [ADDR_W-1:0]                                rowCnt_q;
  logic [H_W-1:0]                                   hCnt_q;
  logic [CH_W-1:0]                                  channel_q;
  logic [output_size-1:0][output_datatype_size-1:0] data_q;
  logic [output_size-1:0][output_datatype_size-1:0] data_d;
  logic signed [output_datatype_size-1:0]           colSat [output_size];

  // Column results beyond output_size are never consumed by any channel.
  logic unusedData;
  assign unusedData = ^i_data;

  function automatic logic signed [ACC_W-1:0] extend(input logic [datatype_size-1:0] x);
    return {{(ACC_W - datatype_size){x[datatype_size-1]}}, x};
  endfunction

  // Clamp an accumulated sum into the signed output range, then apply the
  // optional ReLU on the clamped value.
  function automatic logic signed [output_datatype_size-1:0] saturate(
    input logic signed [ACC_W-1:0] s
  );
    logic signed [CMP_W-1:0]                wide;
    logic signed [CMP_W-1:0]                maxV;
    logic signed [CMP_W-1:0]                minV;
    logic signed [output_datatype_size-1:0] r;
    wide = {{(CMP_W - ACC_W){s[ACC_W-1]}}, s};
    maxV = '0;
    maxV[output_datatype_size-2:0] = '1;
    minV = ~maxV;
    if (wide > maxV) begin
      r = maxV[output_datatype_size-1:0];
    end else if (wide < minV) begin
      r = minV[output_datatype_size-1:0];
    end else begin
      r = wide[output_datatype_size-1:0];
    end
`ifdef CONV_FUNC_RELU_EN
    if (r[output_datatype_size-1]) begin
      r = '0;
    end
`endif
    return r;
  endfunction

  // Each output element k belongs to a fixed horizontal tile and column, so
  // its vertical-tile reduction is built once here and only selected by the
  // tile counter below.
  for (genvar k = 0; k < output_size; k++) begin : g_col
    localparam int H = k / xbar_size;
    localparam int C = k % xbar_size;
    logic signed [ACC_W-1:0] colAcc;

    always_comb begin
      colAcc = '0;
      for (int v = 0; v < v_cim_tiles; v++) begin
        colAcc = colAcc + extend(i_data[H][v][C]);
      end
    end

    assign colSat[k] = saturate(colAcc);
  end

  // Only the elements of the horizontal tile being reduced this cycle are
  // updated; everything else keeps its previous value.
  always_comb begin
    data_d = data_q;
    if (state_q == S_ACCUM) begin
      for (int k = 0; k < output_size; k++) begin
        if (hCnt_q == H_W'(k / xbar_size)) begin
          data_d[k] = colSat[k];
        end
      end
    end
  end

  // Main sequencer. The row counter only moves on cycles that actually
  // issue a write, so a busy crossbar simply freezes the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rowCnt_q  <= '0;
      hCnt_q    <= '0;
      channel_q <= '0;
      data_q    <= '0;
    end else begin
      data_q <= data_d;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q   <= S_WRITE;
            rowCnt_q  <= '0;
            channel_q <= '0;
          end
        end
        S_WRITE: begin
          if (!i_cim_busy) begin
            if (rowCnt_q == ADDR_W'(ROWS - 1)) begin
              rowCnt_q <= '0;
              state_q  <= S_START;
            end else begin
              rowCnt_q <= rowCnt_q + 1'b1;
            end
          end
        end
        S_START: begin
          if (!i_cim_busy) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_cim_done) begin
            hCnt_q  <= '0;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (hCnt_q == H_W'(h_cim_tiles - 1)) begin
            hCnt_q  <= '0;
            state_q <= S_OUT;
          end else begin
            hCnt_q <= hCnt_q + 1'b1;
          end
        end
        S_OUT: begin
          if (i_ready) begin
            if (channel_q == CH_W'(num_channels - 1)) begin
              channel_q <= '0;
              state_q   <= S_IDLE;
            end else begin
              channel_q <= channel_q + 1'b1;
              state_q   <= S_WRITE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Write enable and start follow i_cim_busy in the same cycle so the
  // crossbar never sees a request it has flagged it cannot take.
  assign o_busy      = (state_q != S_IDLE);
  assign o_cim_we    = (state_q == S_WRITE) && !i_cim_busy;
  assign o_cim_start = (state_q == S_START) && !i_cim_busy;
  assign o_cim_addr  = rowCnt_q;
  assign o_channel   = channel_q;
  assign o_valid     = (state_q == S_OUT);
  assign o_data      = data_q;

endmodule

// File: tb/tb_conv_func_acc.sv
// ---------------------------------------------------------------------------
// tb_conv_func_acc
//
// Drives conv_func_acc with randomized crossbar back-pressure, spurious
// start/done pulses and random tile data, and compares the write sequence,
// handshake timing and result vector against a plain-arithmetic model.
// Built with v_cim_tiles = 2 and an 8-bit output so saturation is reachable,
// and output_size not a multiple of xbar_size so the last tile is partial.
// ---------------------------------------------------------------------------
module tb_conv_func_acc;

  localparam int IN_SIZE  = 300;
  localparam int OUT_SIZE = 300;
  localparam int XBAR     = 256;
  localparam int NCH      = 3;
  localparam int DW       = 8;
  localparam int ODW      = 8;
  localparam int H_TILES  = (OUT_SIZE + XBAR - 1) / XBAR;
  localparam int V_TILES  = (IN_SIZE + XBAR - 1) / XBAR;
  localparam int ROWS     = (IN_SIZE < XBAR) ? IN_SIZE : XBAR;
  localparam int ADDR_W   = $clog2(XBAR);
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int OMAX     = (1 << (ODW - 1)) - 1;
  localparam int OMIN     = -(1 << (ODW - 1));

  logic clk;
  logic rst;
  logic iStart;
  logic oBusy;
  logic iCimBusy;
  logic oCimWe;
  logic [ADDR_W-1:0] oCimAddr;
  logic oCimStart;
  logic iCimDone;
  logic [H_TILES-1:0][V_TILES-1:0][XBAR-1:0][DW-1:0] iData;
  logic [CH_W-1:0] oChannel;
  logic oValid;
  logic iReady;
  logic [OUT_SIZE-1:0][ODW-1:0] oData;

  int checkCount;
  int passCount;
  int expVec [OUT_SIZE];

  conv_func_acc #(
    .input_size(IN_SIZE),
    .output_size(OUT_SIZE),
    .xbar_size(XBAR),
    .num_channels(NCH),
    .datatype_size(DW),
    .output_datatype_size(ODW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(iStart),
    .o_busy(oBusy),
    .i_cim_busy(iCimBusy),
    .o_cim_we(oCimWe),
    .o_cim_addr(oCimAddr),
    .o_cim_start(oCimStart),
    .i_cim_done(iCimDone),
    .i_data(iData),
    .o_channel(oChannel),
    .o_valid(oValid),
    .i_ready(iReady),
    .o_data(oData)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence stalls somewhere unbounded.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare o_data against expVec, reporting the first differing element.
  task automatic checkVector(input string tag);
    int idx;
    bit found;
    idx = 0;
    found = 1'b0;
    for (int k = 0; k < OUT_SIZE; k++) begin
      if (!found && (longint'($signed(oData[k])) !== longint'(expVec[k]))) begin
        idx = k;
        found = 1'b1;
      end
    end
    checkOutput($sformatf("%s[%0d]", tag, idx), longint'($signed(oData[idx])), longint'(expVec[idx]));
  endtask

  // Reference: element k is the sum over vertical tiles of column k%XBAR in
  // horizontal tile k/XBAR, clamped to the output range.
  function automatic void computeExpected();
    int sum;
    for (int k = 0; k < OUT_SIZE; k++) begin
      sum = 0;
      for (int v = 0; v < V_TILES; v++) begin
        sum += int'($signed(iData[k / XBAR][v][k % XBAR]));
      end
      if (sum > OMAX) sum = OMAX;
      if (sum < OMIN) sum = OMIN;
`ifdef CONV_FUNC_RELU_EN
      if (sum < 0) sum = 0;
`endif
      expVec[k] = sum;
    end
  endfunction

  // 0: full-range random, 1: all max, 2: all min, 3: small mixed values.
  task automatic fillData(input int pattern);
    for (int h = 0; h < H_TILES; h++) begin
      for (int v = 0; v < V_TILES; v++) begin
        for (int c = 0; c < XBAR; c++) begin
          case (pattern)
            1: iData[h][v][c] = 8'h7F;
            2: iData[h][v][c] = 8'h80;
            3: iData[h][v][c] = 8'(int'($urandom_range(0, 40)) - 20);
            default: iData[h][v][c] = 8'($urandom_range(0, 255));
          endcase
        end
      end
    end
  endtask

  // One full i_start sequence over all channels.
  task automatic applyStimulus(input bit stall, input bit readyAlways, input bit noise, input int basePattern);
    int weCount;
    int cyc;
    int gap;
    int hold;
    bit started;
    iStart = 1'b1;
    iCimBusy = 1'b0;
    iCimDone = 1'b0;
    iReady = readyAlways;
    #1;
    checkOutput("idleBusy", longint'(oBusy), 0);
    tick();
    for (int ch = 0; ch < NCH; ch++) begin
      weCount = 0;
      cyc = 0;
      while (weCount < ROWS && cyc < 4 * ROWS + 50) begin
        iCimBusy = stall ? ($urandom_range(0, 3) == 0) : 1'b0;
        iStart = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
        iCimDone = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
        iReady = readyAlways ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        checkOutput("writeWe", longint'(oCimWe), longint'(!iCimBusy));
        checkOutput("writeAddr", longint'(oCimAddr), longint'(weCount));
        checkOutput("writeChannel", longint'(oChannel), longint'(ch));
        checkOutput("writeStart", longint'(oCimStart), 0);
        if (!iCimBusy) weCount++;
        tick();
        cyc++;
      end
      if (weCount < ROWS) begin
        checkOutput("writeTimeout", longint'(weCount), longint'(ROWS));
        return;
      end
      started = 1'b0;
      cyc = 0;
      while (!started && cyc < 50) begin
        iCimBusy = stall ? 1'($urandom_range(0, 1)) : 1'b0;
        iStart = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        iCimDone = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        checkOutput("startPulse", longint'(oCimStart), longint'(!iCimBusy));
        checkOutput("startWe", longint'(oCimWe), 0);
        checkOutput("startAddr", longint'(oCimAddr), 0);
        started = !iCimBusy;
        tick();
        cyc++;
      end
      if (!started) begin
        checkOutput("startTimeout", 0, 1);
        return;
      end
      iStart = 1'b0;
      iCimDone = 1'b0;
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        iCimBusy = 1'($urandom_range(0, 1));
        #1;
        checkOutput("waitStart", longint'(oCimStart), 0);
        checkOutput("waitBusy", longint'(oBusy), 1);
        tick();
      end
      fillData((basePattern + ch) % 4);
      computeExpected();
      iCimDone = 1'b1;
      #1;
      checkOutput("doneValid", longint'(oValid), 0);
      tick();
      for (int i = 1; i <= H_TILES; i++) begin
        iCimDone = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        checkOutput($sformatf("accumValid%0d", i), longint'(oValid), 0);
        tick();
      end
      iCimDone = 1'b0;
      hold = readyAlways ? 0 : $urandom_range(1, 5);
      for (int j = 0; j < hold; j++) begin
        iReady = 1'b0;
        #1;
        checkOutput("holdValid", longint'(oValid), 1);
        checkVector("holdData");
        tick();
      end
      iReady = 1'b1;
      #1;
      checkOutput("outValid", longint'(oValid), 1);
      checkOutput("outChannel", longint'(oChannel), longint'(ch));
      checkVector("outData");
      tick();
      iReady = readyAlways;
    end
    iCimBusy = 1'b0;
    #1;
    checkOutput("endBusy", longint'(oBusy), 0);
    checkOutput("endValid", longint'(oValid), 0);
    checkOutput("endChannel", longint'(oChannel), 0);
  endtask

  // Run channel 0 up to the first reduction cycle, then reset.
  task automatic resetMidAccum();
    iStart = 1'b1;
    iCimBusy = 1'b0;
    iCimDone = 1'b0;
    iReady = 1'b0;
    tick();
    iStart = 1'b0;
    repeat (ROWS) tick();
    fillData(0);
    tick();
    iCimDone = 1'b1;
    tick();
    iCimDone = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("preResetBusy", longint'(oBusy), 1);
    tick();
    checkOutput("rstBusy", longint'(oBusy), 0);
    checkOutput("rstValid", longint'(oValid), 0);
    checkOutput("rstAddr", longint'(oCimAddr), 0);
    checkOutput("rstChannel", longint'(oChannel), 0);
    for (int k = 0; k < OUT_SIZE; k++) expVec[k] = 0;
    checkVector("rstData");
    rst = 1'b0;
    tick();
  endtask

  initial begin
    checkCount = 0;
    passCount = 0;
    rst = 1'b1;
    iStart = 1'b0;
    iCimBusy = 1'b0;
    iCimDone = 1'b0;
    iReady = 1'b0;
    iData = '0;
    repeat (3) tick();
    checkOutput("resetBusy", longint'(oBusy), 0);
    checkOutput("resetWe", longint'(oCimWe), 0);
    checkOutput("resetStart", longint'(oCimStart), 0);
    checkOutput("resetAddr", longint'(oCimAddr), 0);
    checkOutput("resetChannel", longint'(oChannel), 0);
    checkOutput("resetValid", longint'(oValid), 0);
    for (int k = 0; k < OUT_SIZE; k++) expVec[k] = 0;
    checkVector("resetData");
    rst = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 0);
    resetMidAccum();
    applyStimulus(1'b1, 1'b0, 1'b1, 3);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
